// File: rtl/iram_loadable.sv
// iram_loadable: loadable 16-bit instruction RAM with post-reset clear sweep and byte-stream load port.
// Define IRAM_REG_READ_EN for a registered (1-cycle) fetch path; default is a combinational fetch.
module iram_loadable #(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 128,
    parameter logic [15:0] FILL_WORD = 16'h0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [15:0]       q_o,
    output logic              misalign_o,
    output logic              oor_o,
    output logic              busy_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic [ADDR_W-1:0] ld_count_o,
    output logic              ld_err_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD_LO, LOAD_HI} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [7:0]        hold_q, hold_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              we;
    logic [15:0]       wdata;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-2:0] idx;
    logic [15:0]       rd_data;
    logic              accept;
    logic              last_ptr;

    assign idx        = addr_i[ADDR_W-1:1];
    assign misalign_o = addr_i[0];
    assign oor_o      = {1'b0, idx} >= ADDR_W'(DEPTH);
    assign busy_o     = state_q != IDLE;
    assign ld_ready_o = state_q == LOAD_LO || state_q == LOAD_HI;
    assign ld_count_o = cnt_q;
    assign ld_err_o   = err_q;
    assign accept     = ld_valid_i && ld_ready_o;
    assign last_ptr   = ptr_q == PW'(DEPTH - 1);
    assign rd_data    = (busy_o || oor_o) ? FILL_WORD : mem[idx[PW-1:0]];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we      = 1'b0;
        wdata   = FILL_WORD;
        case (state_q)
            CLEAR: begin
                we      = 1'b1;
                ptr_d   = last_ptr ? '0 : ptr_q + PW'(1);
                state_d = last_ptr ? IDLE : CLEAR;
            end
            IDLE: begin
                if (ld_start_i) begin
                    ptr_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    hold_d = ld_data_i;
                    // An odd-length program pads its final word's high byte with fill.
                    if (ld_last_i) begin
                        we      = 1'b1;
                        wdata   = {FILL_WORD[15:8], ld_data_i};
                        cnt_d   = cnt_q + ADDR_W'(1);
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    we    = 1'b1;
                    wdata = {ld_data_i, hold_q};
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (ld_last_i) begin
                        state_d = IDLE;
                    end else if (last_ptr) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + PW'(1);
                        state_d = LOAD_LO;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && we) mem[ptr_q] <= wdata;
    end

`ifdef IRAM_REG_READ_EN
    logic [15:0] q_q;
    always_ff @(posedge clk_i) begin
        q_q <= !rst_ni ? FILL_WORD : rd_data;
    end
    assign q_o = q_q;
`else
    assign q_o = rd_data;
`endif

endmodule

// File: tb/tb_iram_loadable.sv
// tb_iram_loadable: drives a DEPTH=128 and a DEPTH=4 instance in lockstep and checks both against a byte-stream model.
module tb_iram_loadable;
    logic        clk = 1'b0;
    logic        rst_n, ld_start, ld_valid, ld_last;
    logic [7:0]  ld_data, addr;
    logic [15:0] a_q, b_q;
    logic        a_mis, b_mis, a_oor, b_oor, a_busy, b_busy, a_rdy, b_rdy, a_err, b_err;
    logic [7:0]  a_cnt, b_cnt;

    int checks = 0, errors = 0;
    byte unsigned prog[$];
    bit          rb[$];
    int          acc_a;
    logic [15:0] mm [2][128];
    logic [15:0] fl [2];
    int          dep [2];
    int          mc [2];
    bit          me [2];

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] aq;
        logic        mis;
        logic [15:0] bq;
        logic        boor;
    } vec_t;
    vec_t tv[6];

    iram_loadable #(.ADDR_W(8), .DEPTH(128), .FILL_WORD(16'h0000)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .q_o(a_q), .misalign_o(a_mis), .oor_o(a_oor),
        .busy_o(a_busy), .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_last_i(ld_last), .ld_ready_o(a_rdy), .ld_count_o(a_cnt), .ld_err_o(a_err));

    iram_loadable #(.ADDR_W(8), .DEPTH(4), .FILL_WORD(16'hDEAD)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .q_o(b_q), .misalign_o(b_mis), .oor_o(b_oor),
        .busy_o(b_busy), .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_last_i(ld_last), .ld_ready_o(b_rdy), .ld_count_o(b_cnt), .ld_err_o(b_err));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [7:0] a);
        addr = a;
`ifdef IRAM_REG_READ_EN
        step();
`else
        #1;
`endif
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 128; w++) mm[k][w] = fl[k];
            mc[k] = 0;
            me[k] = 1'b0;
        end
    endtask

    // A byte stream of n bytes fills ceil(n/2) words, truncated at 2*DEPTH bytes.
    task automatic model_load();
        for (int k = 0; k < 2; k++) begin
            int n, nacc, w;
            logic [15:0] f;
            n    = prog.size();
            nacc = (n > 2 * dep[k]) ? 2 * dep[k] : n;
            w    = (nacc + 1) / 2;
            f    = fl[k];
            for (int i = 0; i < w; i++)
                mm[k][i] = {(2 * i + 1 < nacc) ? prog[2 * i + 1] : f[15:8], prog[2 * i]};
            mc[k] = w;
            me[k] = (n > 2 * dep[k]) || (nacc % 2 == 1);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, " a_cnt"}, a_cnt, mc[0]);
        chk({tag, " a_err"}, a_err, me[0]);
        chk({tag, " b_cnt"}, b_cnt, mc[1]);
        chk({tag, " b_err"}, b_err, me[1]);
        for (int w = 0; w < 128; w++) begin
            fetch(8'(2 * w));
            chk($sformatf("%s a_q[%0d]", tag, w), a_q, mm[0][w]);
            chk($sformatf("%s b_q[%0d]", tag, w), b_q, (w < 4) ? mm[1][w] : fl[1]);
            chk($sformatf("%s b_oor[%0d]", tag, w), b_oor, w >= 4);
        end
    endtask

    // gm: 0 back-to-back, 1 valid every other cycle, 2 random gaps; gap cycles carry junk data/last.
    task automatic send(input int gm);
        acc_a = 0;
        rb.delete();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < prog.size(); i++) begin
            int gaps;
            gaps = (gm == 1 && i > 0) ? 1 : (gm == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                ld_last  = 1'b1;
                step();
            end
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == prog.size() - 1);
            if (a_rdy) acc_a++;
            rb.push_back(b_rdy);
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic set_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
    endtask

    initial begin
        int na, nb;
        fl[0] = 16'h0000; fl[1] = 16'hDEAD;
        dep[0] = 128;     dep[1] = 4;
        rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00; addr = 8'h00;
        step(); step();
        chk("rst busy", a_busy, 1);
        chk("rst ready", a_rdy, 0);
        chk("rst q", a_q, 16'h0000);
        chk("rst b_q", b_q, 16'hDEAD);
        chk("rst cnt", a_cnt, 0);
        chk("rst err", a_err, 0);

        rst_n = 1'b1;
        na = 0; nb = 0;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (!b_busy && nb == 0) nb = k;
            if (!a_busy) begin na = k; break; end
        end
        chk("clear len a", na, 128);
        chk("clear len b", nb, 4);
        model_clear();
        fetch(8'd0);   chk("clear q@0", a_q, 16'h0000);
        fetch(8'd2);   chk("clear q@2", a_q, 16'h0000);
        fetch(8'd254); chk("clear q@254", a_q, 16'h0000);
        chk("clear b oor@254", b_oor, 1);

        prog = '{8'h01, 8'hF0, 8'h19, 8'hF2};
        send(0);
        chk("even busy drop", a_busy, 0);
        chk("even cnt", a_cnt, 2);
        chk("even err", a_err, 0);
        chk("even accepted", acc_a, 4);
        model_load();
        tv[0] = '{8'd0,   16'hF001, 1'b0, 16'hF001, 1'b0};
        tv[1] = '{8'd1,   16'hF001, 1'b1, 16'hF001, 1'b0};
        tv[2] = '{8'd2,   16'hF219, 1'b0, 16'hF219, 1'b0};
        tv[3] = '{8'd3,   16'hF219, 1'b1, 16'hF219, 1'b0};
        tv[4] = '{8'd4,   16'h0000, 1'b0, 16'hDEAD, 1'b0};
        tv[5] = '{8'd254, 16'h0000, 1'b0, 16'hDEAD, 1'b1};
        for (int i = 0; i < 6; i++) begin
            fetch(tv[i].addr);
            chk($sformatf("vec%0d a_q", i), a_q, tv[i].aq);
            chk($sformatf("vec%0d mis", i), a_mis, tv[i].mis);
            chk($sformatf("vec%0d a_oor", i), a_oor, 0);
            chk($sformatf("vec%0d b_q", i), b_q, tv[i].bq);
            chk($sformatf("vec%0d b_oor", i), b_oor, tv[i].boor);
        end

        prog = '{8'h01, 8'hF0, 8'h19};
        send(1);
        chk("odd accepted", acc_a, 3);
        fetch(8'd2);
        chk("odd mem1", a_q, 16'h0019);
        chk("odd b mem1", b_q, 16'hDE19);
        model_load();
        cmp_all("odd");

        set_prog(11);
        send(0);
        chk("ovf rdy before 8th", rb[7], 1);
        chk("ovf rdy after 8th", rb[8], 0);
        chk("ovf b_cnt", b_cnt, 4);
        chk("ovf b_err", b_err, 1);
        fetch(8'd8);
        chk("ovf b_oor@8", b_oor, 1);
        chk("ovf b_q@8", b_q, 16'hDEAD);
        model_load();
        cmp_all("ovf");

        for (int r = 0; r < 6; r++) begin
            set_prog(r == 0 ? 8 : r == 1 ? 9 : r == 2 ? 1 : int'($urandom_range(2, 40)));
            ld_valid = 1'b1;
            ld_data  = 8'hA5;
            step();
            send(2);
            model_load();
            cmp_all($sformatf("rnd%0d", r));
        end

        set_prog(6);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            step();
        end
        ld_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("midrst busy", a_busy, 1);
        chk("midrst ready", a_rdy, 0);
        chk("midrst cnt", a_cnt, 0);
        chk("midrst err", a_err, 0);
        chk("midrst b_cnt", b_cnt, 0);
        rst_n = 1'b1;
        ld_start = 1'b1;
        na = 0;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (!a_busy) begin na = k; break; end
        end
        ld_start = 1'b0;
        chk("midrst clear len", na, 128);
        step();
        chk("start in clear ignored", a_rdy, 0);
        model_clear();
        cmp_all("midrst");

        prog = '{8'h01, 8'hF0, 8'h19, 8'hF2};
        send(0);
`ifdef IRAM_REG_READ_EN
        addr = 8'd0;
        step(); step();
        chk("reg q@0", a_q, 16'hF001);
        addr = 8'd2;
        #1;
        chk("reg q not comb", a_q, 16'hF001);
        step();
        chk("reg q@2 next edge", a_q, 16'hF219);
`else
        addr = 8'd0;
        #1;
        chk("comb q@0", a_q, 16'hF001);
        addr = 8'd2;
        #1;
        chk("comb q@2", a_q, 16'hF219);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iram_loadable.md
# iram_loadable

Parametrised, loadable instruction memory for the 16-bit single-cycle processor. It replaces the fixed reset-time program image with a RAM that has three jobs:
- clear itself after reset;
- accept a program as a byte stream over a valid/ready load port;
- serve word fetches from a byte address on the processor side.

The fetch port sits between the PC and the decoder. The load port is driven by the board-level programmer/UART bridge.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of the fetch port; word index = ADDR[ADDR_W-1:1]
- DEPTH, 128, number of 16-bit words; must be ≤ 2^(ADDR_W-1) and ≥ 2
- FILL_WORD, 16'h0000, value written by the clear sweep and returned while BUSY

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  synchronous, active-low reset
- ADDR  in  ADDR_W  fetch byte address
- Q  out  16  fetched instruction
- MISALIGN  out  1  ADDR[0]==1 (combinational)
- OOR  out  1  word index ≥ DEPTH (combinational); Q = FILL_WORD when set
- BUSY  out  1  high in CLEAR, LOAD_LO, LOAD_HI; the core must stall while high
- LD_START  in  1  begin a load (sampled in IDLE only)
- LD_VALID  in  1  byte valid
- LD_DATA  in  8  load byte; low byte of each word first
- LD_LAST  in  1  qualifies the final byte of the program
- LD_READY  out  1  high in LOAD_LO/LOAD_HI
- LD_COUNT  out  ADDR_W  words written by the current/last load
- LD_ERR  out  1  sticky error of the last load; cleared by LD_START or reset

## Operation
- States: CLEAR, IDLE, LOAD_LO, LOAD_HI. Word pointer `ptr` ranges 0..DEPTH-1.
- Reset (RESET_N=0 at an edge) gives:
  - state=CLEAR, ptr=0, LD_COUNT=0, LD_ERR=0, hold reg=0;
  - outputs: BUSY=1, LD_READY=0, Q=FILL_WORD.
- CLEAR:
  - Each edge with RESET_N=1 writes FILL_WORD to mem[ptr], then ptr++.
  - After writing DEPTH-1 the block moves to IDLE.
- IDLE:
  - Q = mem[ADDR[ADDR_W-1:1]].
  - LD_START=1 sets ptr=0, LD_COUNT=0, LD_ERR=0 and moves to LOAD_LO.
  - Memory is not cleared by LD_START; words beyond the new program keep their old contents.
- A byte is accepted only on an edge with LD_VALID & LD_READY. LD_VALID without LD_READY is ignored.
- LOAD_LO:
  - Accepted byte → hold reg.
  - If LD_LAST=1 (odd length): write {FILL_WORD[15:8], byte} to mem[ptr], LD_COUNT++, LD_ERR=1, go to IDLE.
  - Otherwise go to LOAD_HI.
- LOAD_HI:
  - Accepted byte → write {byte, hold} to mem[ptr], LD_COUNT++.
  - If LD_LAST=1, go to IDLE.
  - Else if ptr==DEPTH-1 (overflow), set LD_ERR=1 and go to IDLE.
  - Else ptr++ and go to LOAD_LO.
- LD_START outside IDLE is ignored.
- RESET_N=0 in any state aborts immediately and restarts CLEAR. A partially loaded program is then erased.
- Q=FILL_WORD whenever BUSY=1 or OOR=1.
- MISALIGN is reported only; the fetch still uses ADDR[ADDR_W-1:1].

## Timing
- CLEAR lasts exactly DEPTH edges after the first edge with RESET_N=1. BUSY falls on the edge that writes word DEPTH-1.
- Fetch latency:
  - Combinational (0 cycles) by default.
  - 1 cycle with the Configuration macro.
- LD_READY is a registered state decode. It is high the cycle after the LD_START edge, so at most one byte per cycle is accepted.
- A written word is visible on Q the cycle after its write edge, once BUSY=0.
- LD_COUNT and LD_ERR update on the same edge as the write that causes them.
- BUSY falls on the same edge that accepts the LAST or overflow byte.
- Zero-wait streaming is supported: N bytes take N cycles.

## Configuration
- IRAM_REG_READ_EN
  - Defined: Q is registered. It samples mem[index] (or FILL_WORD when BUSY/OOR) on each edge, giving 1-cycle fetch latency. Q resets to FILL_WORD.
  - Undefined: Q is a combinational read, matching the single-cycle core's fetch.
  - MISALIGN and OOR stay combinational in both builds.

## Test plan
- Reset, DEPTH=128: release RESET_N → BUSY=1 for exactly 128 cycles, then 0. Q=16'h0000 at ADDR=0, 2 and 254.
- Even load: LD_START, then bytes 0x01,0xF0,0x19,0xF2 streamed back-to-back, LAST on the 4th → BUSY drops on that edge, LD_COUNT=2, LD_ERR=0. ADDR=0 → Q=16'hF001; ADDR=2 → Q=16'hF219; ADDR=3 → Q=16'hF219 with MISALIGN=1.
- Odd load with gaps: LD_VALID toggling every other cycle, bytes 0x01,0xF0,0x19 with LAST on the 3rd → mem[1]=16'h0019, LD_COUNT=2, LD_ERR=1. Exactly 3 bytes accepted.
- Overflow, DEPTH=4: 10 bytes streamed without LAST → LD_READY=0 after the 8th byte, LD_COUNT=4, LD_ERR=1. Bytes 9–10 are not written. ADDR=8 → OOR=1, Q=FILL_WORD.
- Reset mid-load: RESET_N=0 after the 3rd byte → the next cycle shows BUSY=1, LD_READY=0, LD_COUNT=0, LD_ERR=0. After the clear, all words = FILL_WORD. LD_START asserted during CLEAR is ignored.
- IRAM_REG_READ_EN defined: change ADDR 0→2 after the even load → Q shows 16'hF219 one edge later, not combinationally.
